// File: rtl/polara_loopback_pkg.sv
// Shared definitions for the Polara NoC loopback scheduler: header layout,
// channel encodings, FSM states and the saturating counter helper.
package polara_loopback_pkg;

    localparam int HDR_W       = 64;
    localparam int CHIPID_LSB  = 50;
    localparam int CHIPID_W    = 14;
    localparam int X_LSB       = 42;
    localparam int X_W         = 8;
    localparam int Y_LSB       = 34;
    localparam int Y_W         = 8;
    localparam int FBITS_LSB   = 30;
    localparam int FBITS_W     = 4;
    localparam int LEN_LSB     = 22;
    localparam int LEN_W       = 8;
    localparam int MSGTYPE_LSB = 14;
    localparam int MSGTYPE_W   = 8;
    localparam int MSHR_LSB    = 6;
    localparam int MSHR_W      = 8;
    localparam int RSVD_W      = 6;
    localparam int CNT_W       = 16;

    localparam logic [FBITS_W-1:0]   FBITS_VAL        = 4'b0010;
    localparam logic [MSGTYPE_W-1:0] MSG_TYPE_INV_FWD = 8'd18;

    localparam logic [1:0] CH_NOC1  = 2'b00;
    localparam logic [1:0] CH_NOC2  = 2'b01;
    localparam logic [1:0] CH_NOC3  = 2'b10;
    localparam logic [1:0] CH_MARCH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_ADV  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Adds a small event count to a bring-up counter, pinning at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [2:0]       amt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {14'd0, amt};
        if (sum[CNT_W]) begin
            sat_inc = 16'hFFFF;
        end else begin
            sat_inc = sum[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/polara_loopback_hdr_fmt.sv
// Combinational builder for the single-flit loopback header; one instance
// serves both the transmitted flit and the expected returned flit.
module polara_loopback_hdr_fmt
    import polara_loopback_pkg::*;
(
    input  logic [MSHR_W-1:0]    i_pkt_idx,
    input  logic [CHIPID_W-1:0]  i_chipid,
    input  logic [MSGTYPE_W-1:0] i_msg_type,
    output logic [HDR_W-1:0]     o_hdr
);

    // Pack the header fields; X, Y, LEN and reserved bits stay zero.
    always_comb begin
        o_hdr                              = 64'd0;
        o_hdr[CHIPID_LSB  +: CHIPID_W]     = i_chipid;
        o_hdr[X_LSB       +: X_W]          = 8'd0;
        o_hdr[Y_LSB       +: Y_W]          = 8'd0;
        o_hdr[FBITS_LSB   +: FBITS_W]      = FBITS_VAL;
        o_hdr[LEN_LSB     +: LEN_W]        = 8'd0;
        o_hdr[MSGTYPE_LSB +: MSGTYPE_W]    = i_msg_type;
        o_hdr[MSHR_LSB    +: MSHR_W]       = i_pkt_idx;
        o_hdr[RSVD_W-1:0]                  = 6'd0;
    end

endmodule

// File: rtl/polara_loopback_scheduler.sv
// Loopback traffic sequencer between the chipset and the Polara NoC ports:
// sends header flits on one channel (or marches 1->2->3) and checks echoes.
module polara_loopback_scheduler
    import polara_loopback_pkg::*;
#(
    parameter int unsigned         PKTS_PER_CH    = 16,
    parameter int unsigned         TIMEOUT_CYCLES = 4096,
    parameter logic [CHIPID_W-1:0] CHIPID         = 14'h2000,
    parameter logic [7:0]          MSG_TYPE       = MSG_TYPE_INV_FWD
) (
    input  logic              chipset_clk,
    input  logic              chipset_rst,
    input  logic              start,
    input  logic [1:0]        sw_channel,
    output logic [HDR_W-1:0]  chipset_intf_data_noc1,
    output logic [HDR_W-1:0]  chipset_intf_data_noc2,
    output logic [HDR_W-1:0]  chipset_intf_data_noc3,
    output logic              chipset_intf_val_noc1,
    output logic              chipset_intf_val_noc2,
    output logic              chipset_intf_val_noc3,
    input  logic              chipset_intf_rdy_noc1,
    input  logic              chipset_intf_rdy_noc2,
    input  logic              chipset_intf_rdy_noc3,
    input  logic [HDR_W-1:0]  intf_chipset_data_noc1,
    input  logic [HDR_W-1:0]  intf_chipset_data_noc2,
    input  logic [HDR_W-1:0]  intf_chipset_data_noc3,
    input  logic              intf_chipset_val_noc1,
    input  logic              intf_chipset_val_noc2,
    input  logic              intf_chipset_val_noc3,
    output logic              intf_chipset_rdy_noc1,
    output logic              intf_chipset_rdy_noc2,
    output logic              intf_chipset_rdy_noc3,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout_seen,
    output logic [CNT_W-1:0]  sent_count,
    output logic [CNT_W-1:0]  recv_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKTS_PER_CH - 1);
    localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    logic [1:0]       r_ch;
    logic             r_march;
    logic [CNT_W-1:0] r_pkt_idx;
    logic [31:0]      r_timer;
    logic [2:0]       r_tx_val;
    logic [HDR_W-1:0] r_tx_data [3];
    logic             r_sink_rdy;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_recv;
    logic [CNT_W-1:0] r_err;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;

    state_e           w_state_nxt;
    logic [1:0]       w_ch_nxt;
    logic             w_march_nxt;
    logic [CNT_W-1:0] w_idx_nxt;
    logic [31:0]      w_timer_nxt;
    logic             w_start_acc;
    logic             w_accept;
    logic             w_ch_hit;
    logic             w_match;
    logic             w_timeout;
    logic [HDR_W-1:0] w_hdr;
    logic             w_sel_tx_rdy;
    logic             w_sel_rx_val;
    logic [HDR_W-1:0] w_sel_rx_data;
    logic [2:0]       w_sel_mask;
    logic [2:0]       w_rx_vld;
    logic [2:0]       w_stray_vec;
    logic [2:0]       w_stray_cnt;
    logic [2:0]       w_err_amt;
    logic [2:0]       w_load_mask;
    logic [CNT_W-1:0] w_sent_nxt;
    logic [CNT_W-1:0] w_recv_nxt;
    logic [CNT_W-1:0] w_err_nxt;

    // WAIT keeps pkt_idx unchanged, so the next index feeds both the flit
    // being loaded for SEND and the value the echo is compared against.
    polara_loopback_hdr_fmt u_hdr_fmt (
        .i_pkt_idx  (w_idx_nxt[MSHR_W-1:0]),
        .i_chipid   (CHIPID),
        .i_msg_type (MSG_TYPE),
        .o_hdr      (w_hdr)
    );

    assign w_rx_vld = {intf_chipset_val_noc3, intf_chipset_val_noc2, intf_chipset_val_noc1}
                      & {3{r_sink_rdy}};

    // Select the ready, return valid and return data of the active channel.
    always_comb begin
        w_sel_tx_rdy  = 1'b0;
        w_sel_rx_val  = 1'b0;
        w_sel_rx_data = 64'd0;
        w_sel_mask    = 3'b000;
        case (r_ch)
            CH_NOC1: begin
                w_sel_tx_rdy  = chipset_intf_rdy_noc1;
                w_sel_rx_val  = w_rx_vld[0];
                w_sel_rx_data = intf_chipset_data_noc1;
                w_sel_mask    = 3'b001;
            end
            CH_NOC2: begin
                w_sel_tx_rdy  = chipset_intf_rdy_noc2;
                w_sel_rx_val  = w_rx_vld[1];
                w_sel_rx_data = intf_chipset_data_noc2;
                w_sel_mask    = 3'b010;
            end
            CH_NOC3: begin
                w_sel_tx_rdy  = chipset_intf_rdy_noc3;
                w_sel_rx_val  = w_rx_vld[2];
                w_sel_rx_data = intf_chipset_data_noc3;
                w_sel_mask    = 3'b100;
            end
            default: begin
                w_sel_tx_rdy  = 1'b0;
                w_sel_rx_val  = 1'b0;
                w_sel_rx_data = 64'd0;
                w_sel_mask    = 3'b000;
            end
        endcase
    end

    // Next-state logic and per-cycle event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_march_nxt = r_march;
        w_idx_nxt   = r_pkt_idx;
        w_timer_nxt = r_timer;
        w_start_acc = 1'b0;
        w_accept    = 1'b0;
        w_ch_hit    = 1'b0;
        w_match     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_march_nxt = (sw_channel == CH_MARCH);
                    w_ch_nxt    = (sw_channel == CH_MARCH) ? CH_NOC1 : sw_channel;
                    w_idx_nxt   = 16'd0;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_SEND: begin
                if (w_sel_tx_rdy) begin
                    w_accept    = 1'b1;
                    w_timer_nxt = 32'd0;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_WAIT: begin
                w_timer_nxt = r_timer + 32'd1;
                if (w_sel_rx_val) begin
                    w_ch_hit    = 1'b1;
                    w_match     = (w_sel_rx_data == w_hdr);
                    w_state_nxt = ST_ADV;
                end else if (r_timer == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_ADV;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ADV: begin
                if (r_pkt_idx == PKT_LAST) begin
                    if (r_march && (r_ch != CH_NOC3)) begin
                        w_ch_nxt    = r_ch + 2'd1;
                        w_idx_nxt   = 16'd0;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_idx_nxt   = r_pkt_idx + 16'd1;
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter updates: a new run restarts from zero, errors sum all sources.
    always_comb begin
        w_stray_vec = w_rx_vld & ~((r_state == ST_WAIT) ? w_sel_mask : 3'b000);
        w_stray_cnt = {2'b00, w_stray_vec[0]} + {2'b00, w_stray_vec[1]} + {2'b00, w_stray_vec[2]};
        w_err_amt   = w_stray_cnt + {2'b00, w_ch_hit & ~w_match} + {2'b00, w_timeout};
        w_sent_nxt  = sat_inc(w_start_acc ? 16'd0 : r_sent, {2'b00, w_accept});
        w_recv_nxt  = sat_inc(w_start_acc ? 16'd0 : r_recv, {2'b00, w_ch_hit & w_match});
        w_err_nxt   = sat_inc(w_start_acc ? 16'd0 : r_err, w_err_amt);
    end

    // One-hot of the channel that drives a flit in the next cycle.
    always_comb begin
        w_load_mask = 3'b000;
        if (w_state_nxt == ST_SEND) begin
            case (w_ch_nxt)
                CH_NOC1: w_load_mask = 3'b001;
                CH_NOC2: w_load_mask = 3'b010;
                CH_NOC3: w_load_mask = 3'b100;
                default: w_load_mask = 3'b000;
            endcase
        end else begin
            w_load_mask = 3'b000;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            r_state    <= ST_IDLE;
            r_ch       <= CH_NOC1;
            r_march    <= 1'b0;
            r_pkt_idx  <= 16'd0;
            r_timer    <= 32'd0;
            r_tx_val   <= 3'b000;
            for (int c = 0; c < 3; c++) begin
                r_tx_data[c] <= 64'd0;
            end
            r_sink_rdy <= 1'b0;
            r_sent     <= 16'd0;
            r_recv     <= 16'd0;
            r_err      <= 16'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ch       <= w_ch_nxt;
            r_march    <= w_march_nxt;
            r_pkt_idx  <= w_idx_nxt;
            r_timer    <= w_timer_nxt;
            r_tx_val   <= w_load_mask;
            for (int c = 0; c < 3; c++) begin
                if (w_load_mask[c]) begin
                    r_tx_data[c] <= w_hdr;
                end
            end
            r_sink_rdy <= 1'b1;
            r_sent     <= w_sent_nxt;
            r_recv     <= w_recv_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_ADV);
            r_done     <= (w_state_nxt == ST_DONE);
            r_pass     <= (w_state_nxt == ST_DONE) && (w_err_nxt == 16'd0) && (w_recv_nxt == w_sent_nxt);
            r_timeout  <= w_start_acc ? 1'b0 : (r_timeout | w_timeout);
        end
    end

    assign chipset_intf_val_noc1  = r_tx_val[0];
    assign chipset_intf_val_noc2  = r_tx_val[1];
    assign chipset_intf_val_noc3  = r_tx_val[2];
    assign chipset_intf_data_noc1 = r_tx_data[0];
    assign chipset_intf_data_noc2 = r_tx_data[1];
    assign chipset_intf_data_noc3 = r_tx_data[2];
    assign intf_chipset_rdy_noc1  = r_sink_rdy;
    assign intf_chipset_rdy_noc2  = r_sink_rdy;
    assign intf_chipset_rdy_noc3  = r_sink_rdy;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign pass                   = r_pass;
    assign timeout_seen           = r_timeout;
    assign sent_count             = r_sent;
    assign recv_count             = r_recv;
    assign err_count              = r_err;

endmodule

// File: tb/tb_polara_loopback_scheduler.sv
// Scoreboard bench for polara_loopback_scheduler: expected flits are queued at
// start, popped on each accepted send; an echo model returns them to the DUT.
module tb_polara_loopback_scheduler;

    localparam int PKTS = 4;
    localparam int TMO  = 16;
    localparam logic [63:0] FLIP13 = 64'h0000_0000_0000_2000;

    logic        chipset_clk = 1'b0;
    logic        chipset_rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sw_channel = 2'b00;
    logic [63:0] chipset_intf_data_noc1, chipset_intf_data_noc2, chipset_intf_data_noc3;
    logic        chipset_intf_val_noc1, chipset_intf_val_noc2, chipset_intf_val_noc3;
    logic        chipset_intf_rdy_noc1 = 1'b0, chipset_intf_rdy_noc2 = 1'b0, chipset_intf_rdy_noc3 = 1'b0;
    logic [63:0] intf_chipset_data_noc1 = 64'd0, intf_chipset_data_noc2 = 64'd0, intf_chipset_data_noc3 = 64'd0;
    logic        intf_chipset_val_noc1 = 1'b0, intf_chipset_val_noc2 = 1'b0, intf_chipset_val_noc3 = 1'b0;
    logic        intf_chipset_rdy_noc1, intf_chipset_rdy_noc2, intf_chipset_rdy_noc3;
    logic        busy, done, pass, timeout_seen;
    logic [15:0] sent_count, recv_count, err_count;

    always #5 chipset_clk = ~chipset_clk;

    polara_loopback_scheduler #(
        .PKTS_PER_CH    (PKTS),
        .TIMEOUT_CYCLES (TMO),
        .CHIPID         (14'h2000),
        .MSG_TYPE       (8'd18)
    ) dut (
        .chipset_clk            (chipset_clk),
        .chipset_rst            (chipset_rst),
        .start                  (start),
        .sw_channel             (sw_channel),
        .chipset_intf_data_noc1 (chipset_intf_data_noc1),
        .chipset_intf_data_noc2 (chipset_intf_data_noc2),
        .chipset_intf_data_noc3 (chipset_intf_data_noc3),
        .chipset_intf_val_noc1  (chipset_intf_val_noc1),
        .chipset_intf_val_noc2  (chipset_intf_val_noc2),
        .chipset_intf_val_noc3  (chipset_intf_val_noc3),
        .chipset_intf_rdy_noc1  (chipset_intf_rdy_noc1),
        .chipset_intf_rdy_noc2  (chipset_intf_rdy_noc2),
        .chipset_intf_rdy_noc3  (chipset_intf_rdy_noc3),
        .intf_chipset_data_noc1 (intf_chipset_data_noc1),
        .intf_chipset_data_noc2 (intf_chipset_data_noc2),
        .intf_chipset_data_noc3 (intf_chipset_data_noc3),
        .intf_chipset_val_noc1  (intf_chipset_val_noc1),
        .intf_chipset_val_noc2  (intf_chipset_val_noc2),
        .intf_chipset_val_noc3  (intf_chipset_val_noc3),
        .intf_chipset_rdy_noc1  (intf_chipset_rdy_noc1),
        .intf_chipset_rdy_noc2  (intf_chipset_rdy_noc2),
        .intf_chipset_rdy_noc3  (intf_chipset_rdy_noc3),
        .busy                   (busy),
        .done                   (done),
        .pass                   (pass),
        .timeout_seen           (timeout_seen),
        .sent_count             (sent_count),
        .recv_count             (recv_count),
        .err_count              (err_count)
    );

    typedef struct { int ch; int idx; logic [63:0] data; } sb_t;
    typedef struct { int due; int ch; logic [63:0] data; } echo_t;

    sb_t         sb[$];
    echo_t       eq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          cfg_stall = 0;
    int          cfg_drop_idx = -1;
    int          cfg_flip_idx = -1;
    int          cfg_stray_idx = -1;
    int          stall_left = 0;
    int          to_acc_cyc = -1;
    int          to_checked = 0;
    logic        p_to = 1'b0;
    logic [2:0]  pv = 3'b000;
    logic [2:0]  pacc = 3'b000;
    logic [63:0] pd [3];

    function automatic logic [63:0] exp_hdr(input int idx);
        logic [7:0] mshr;
        mshr = idx[7:0];
        return {14'h2000, 8'd0, 8'd0, 4'b0010, 8'd0, 8'd18, mshr, 6'd0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe outputs at negedge, run the sink/echo model, drive inputs.
    task automatic tick();
        logic [2:0]  ov;
        logic [2:0]  rdy;
        logic [63:0] od [3];
        sb_t         e;
        echo_t       r;
        @(negedge chipset_clk);
        start       = 1'b0;
        chipset_rst = 1'b0;
        cyc++;
        ov    = {chipset_intf_val_noc3, chipset_intf_val_noc2, chipset_intf_val_noc1};
        od[0] = chipset_intf_data_noc1;
        od[1] = chipset_intf_data_noc2;
        od[2] = chipset_intf_data_noc3;
        rdy   = 3'b000;
        for (int c = 0; c < 3; c++) begin
            if (pacc[c]) chk("val_drop_after_accept", {63'd0, ov[c]}, 64'd0);
            if (ov[c] && !pacc[c]) begin
                if (sb.size() == 0) begin
                    chk("tx_unexpected_val", {63'd0, ov[c]}, 64'd0);
                end else begin
                    chk("tx_channel", 64'(c), 64'(sb[0].ch));
                    if (pv[c]) chk("tx_hold_stable", od[c], pd[c]);
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        e = sb.pop_front();
                        chk("tx_data", od[c], e.data);
                        rdy[c]     = 1'b1;
                        stall_left = cfg_stall;
                        if (e.idx == cfg_drop_idx) begin
                            to_acc_cyc = cyc;
                        end else begin
                            eq.push_back('{cyc + 3, c, (e.idx == cfg_flip_idx) ? (e.data ^ FLIP13) : e.data});
                        end
                        if (e.idx == cfg_stray_idx) eq.push_back('{cyc + 3, 2, 64'hDEAD_BEEF_0000_0001});
                    end
                end
            end
        end
        if (timeout_seen && !p_to && to_acc_cyc >= 0) begin
            chk("timeout_latency", 64'(cyc - to_acc_cyc), 64'd17);
            to_checked = 1;
        end
        p_to = timeout_seen;
        pv   = ov;
        pacc = rdy;
        for (int c = 0; c < 3; c++) pd[c] = od[c];
        chipset_intf_rdy_noc1  = rdy[0];
        chipset_intf_rdy_noc2  = rdy[1];
        chipset_intf_rdy_noc3  = rdy[2];
        intf_chipset_val_noc1  = 1'b0;
        intf_chipset_val_noc2  = 1'b0;
        intf_chipset_val_noc3  = 1'b0;
        intf_chipset_data_noc1 = 64'd0;
        intf_chipset_data_noc2 = 64'd0;
        intf_chipset_data_noc3 = 64'd0;
        while (eq.size() > 0 && eq[0].due <= cyc) begin
            r = eq.pop_front();
            case (r.ch)
                0: begin intf_chipset_val_noc1 = 1'b1; intf_chipset_data_noc1 = r.data;
                         chk("sink_rdy1", {63'd0, intf_chipset_rdy_noc1}, 64'd1); end
                1: begin intf_chipset_val_noc2 = 1'b1; intf_chipset_data_noc2 = r.data;
                         chk("sink_rdy2", {63'd0, intf_chipset_rdy_noc2}, 64'd1); end
                default: begin intf_chipset_val_noc3 = 1'b1; intf_chipset_data_noc3 = r.data;
                         chk("sink_rdy3", {63'd0, intf_chipset_rdy_noc3}, 64'd1); end
            endcase
        end
    endtask

    task automatic do_reset(input string tag);
        sb.delete();
        eq.delete();
        pv          = 3'b000;
        pacc        = 3'b000;
        stall_left  = 0;
        chipset_rst = 1'b1;
        tick();
        chk({tag, "_sent"}, 64'(sent_count), 64'd0);
        chk({tag, "_recv"}, 64'(recv_count), 64'd0);
        chk({tag, "_err"}, 64'(err_count), 64'd0);
        chk({tag, "_flags"}, {60'd0, busy, done, pass, timeout_seen}, 64'd0);
        chk({tag, "_val"}, {61'd0, chipset_intf_val_noc3, chipset_intf_val_noc2, chipset_intf_val_noc1}, 64'd0);
        chk({tag, "_sink_rdy"}, {61'd0, intf_chipset_rdy_noc3, intf_chipset_rdy_noc2, intf_chipset_rdy_noc1}, 64'd0);
    endtask

    task automatic do_start(input string tag, input logic [1:0] sw);
        int first;
        first = (sw == 2'b11) ? 0 : int'(sw);
        for (int ch = 0; ch < 3; ch++) begin
            if ((sw == 2'b11) || (ch == int'(sw))) begin
                for (int i = 0; i < PKTS; i++) sb.push_back('{ch, i, exp_hdr(i)});
            end
        end
        stall_left = cfg_stall;
        to_acc_cyc = -1;
        to_checked = 0;
        sw_channel = sw;
        start      = 1'b1;
        tick();
        chk({tag, "_start_val"}, {61'd0, chipset_intf_val_noc3, chipset_intf_val_noc2, chipset_intf_val_noc1},
            64'd1 << first);
        chk({tag, "_start_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_start_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_start_sent"}, 64'(sent_count), 64'd0);
        chk({tag, "_start_err"}, 64'(err_count), 64'd0);
    endtask

    task automatic finish_run(input string tag, input int es, input int er, input int ee,
                              input int et, input int ep);
        int k;
        k = 0;
        while (!done && k < 3000) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_sent"}, 64'(sent_count), 64'(es));
        chk({tag, "_recv"}, 64'(recv_count), 64'(er));
        chk({tag, "_err"}, 64'(err_count), 64'(ee));
        chk({tag, "_timeout_seen"}, {63'd0, timeout_seen}, 64'(et));
        chk({tag, "_pass"}, {63'd0, pass}, 64'(ep));
        chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic set_cfg(input int stall, input int drop, input int flip, input int stray);
        cfg_stall     = stall;
        cfg_drop_idx  = drop;
        cfg_flip_idx  = flip;
        cfg_stray_idx = stray;
    endtask

    initial begin
        for (int c = 0; c < 3; c++) pd[c] = 64'd0;
        do_reset("rst0");

        set_cfg(0, -1, -1, -1);
        do_start("noc2", 2'b01);
        finish_run("noc2", 4, 4, 0, 0, 1);

        set_cfg(5, -1, -1, -1);
        do_start("march", 2'b11);
        finish_run("march", 12, 12, 0, 0, 1);

        set_cfg(0, 2, -1, -1);
        do_start("drop", 2'b00);
        finish_run("drop", 4, 3, 1, 1, 0);
        chk("drop_timeout_observed", 64'(to_checked), 64'd1);

        set_cfg(0, -1, 1, 1);
        do_start("flip", 2'b00);
        finish_run("flip", 4, 3, 2, 0, 0);

        set_cfg(0, -1, -1, -1);
        do_start("midrst", 2'b10);
        tick();
        chk("midrst_pre_sent", 64'(sent_count), 64'd1);
        do_reset("midrst");
        do_start("postrst", 2'b10);
        finish_run("postrst", 4, 4, 0, 0, 1);

        do_start("ign", 2'b01);
        for (int k = 0; k < 200 && sent_count != 16'd2; k++) tick();
        chk("ign_pre_sent", 64'(sent_count), 64'd2);
        sw_channel = 2'b00;
        start      = 1'b1;
        tick();
        chk("ign_sent_kept", 64'(sent_count), 64'd2);
        chk("ign_busy", {63'd0, busy}, 64'd1);
        finish_run("ign", 4, 4, 0, 0, 1);
        do_start("restart", 2'b00);
        finish_run("restart", 4, 4, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
